// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : audio_pkg                                                       |
// | Purpose  : Shared constants and helpers for the I2S transmitter slice:     |
// |            serial format encoding, slot length and slot image builder.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package audio_pkg;

  localparam int SLOT_BITS = 32;

  // Format encoding as presented on the fmt port; code 3 is reserved and
  // falls back to plain I2S.
  typedef enum logic [1:0] {
    FMT_I2S  = 2'd0,
    FMT_LJ   = 2'd1,
    FMT_RJ   = 2'd2,
    FMT_RSVD = 2'd3
  } fmt_e;

  // Build one 32-bit slot image, bit 31 = first bit on the wire (p=0).
  // ext carries the sample zero-extended into its low `width` bits, so the
  // justification is just a left shift that moves the sample MSB to the
  // required slot position; everything else is left as zero.
  function automatic logic [SLOT_BITS-1:0] place_slot(
    input logic [SLOT_BITS-1:0] ext,
    input fmt_e                 fmt,
    input int                   width
  );
    logic [SLOT_BITS-1:0] img;
    case (fmt)
      FMT_LJ:  img = ext << (SLOT_BITS - width);
      FMT_RJ:  img = ext;
      default: img = ext << (SLOT_BITS - 1 - width);
    endcase
    return img;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frac_clk_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frac_clk_div                                                    |
// | Purpose  : Fractional tick generator. Produces an average tick rate of     |
// |            NUM/DEN ticks per clock using a phase accumulator.              |
// | Ports    : clk_sys (in)  system clock                                      |
// |            reset   (in)  synchronous active-high reset, clears the phase   |
// |            tick    (out) one-cycle strobe                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module frac_clk_div #(
  parameter longint unsigned NUM = 64'd6_144_000,
  parameter longint unsigned DEN = 64'd64_000_000
) (
  input  logic clk_sys,
  input  logic reset,
  output logic tick
);

  // acc_q never exceeds DEN-1, so acc_q + NUM <= DEN + NUM - 1 fits here.
  localparam int              ACC_W = $clog2(NUM + DEN);
  localparam logic [ACC_W-1:0] NUM_C = ACC_W'(NUM);
  localparam logic [ACC_W-1:0] DEN_C = ACC_W'(DEN);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_sum;

  always_comb begin
    acc_sum = acc_q + NUM_C;
    acc_d   = acc_sum;
    tick    = 1'b0;
    if (acc_sum >= DEN_C) begin
      acc_d = acc_sum - DEN_C;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : audio_i2s_tx                                                    |
// | Purpose  : Stereo serial audio transmitter (I2S / left- / right-justified) |
// |            with a one-pair holding register and underrun counting.         |
// | Ports    : clk_sys       (in)  sole clock                                  |
// |            reset         (in)  synchronous active-high reset               |
// |            fmt[1:0]      (in)  0=I2S 1=LJ 2=RJ 3=I2S, sampled per frame    |
// |            left/right    (in)  WIDTH-bit sample pair                       |
// |            sample_valid  (in)  pair presented                              |
// |            sample_ready  (out) holding register empty                      |
// |            sclk          (out) bit clock, 64*fs average                    |
// |            lrclk         (out) word select, 0 = left slot                  |
// |            sdata         (out) serial data, MSB first                      |
// |            underrun_cnt  (out) saturating count of repeated frames         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned CLK_RATE    = 64_000_000,
  parameter int unsigned SAMPLE_RATE = 48_000,
  parameter int          WIDTH       = 16,   // legal 8..24
  parameter int          SIGNED_IN   = 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [1:0]       fmt,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             sclk,
  output logic             lrclk,
  output logic             sdata,
  output logic [7:0]       underrun_cnt
);

  // Offset-binary inputs become two's complement by flipping the MSB.
  localparam logic [WIDTH-1:0] MSB_FLIP = {(SIGNED_IN == 0), {(WIDTH-1){1'b0}}};

  logic tick;

  frac_clk_div #(
    .NUM (64'(128) * 64'(SAMPLE_RATE)),
    .DEN (64'(CLK_RATE))
  ) u_div (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tick    (tick)
  );

  logic                   sclk_q,      sclk_d;
  logic                   lrclk_q,     lrclk_d;
  logic                   sdata_q,     sdata_d;
  logic [5:0]             bit_cnt_q,   bit_cnt_d;
  logic [2*SLOT_BITS-1:0] shift_q,     shift_d;
  logic [WIDTH-1:0]       prev_l_q,    prev_l_d;
  logic [WIDTH-1:0]       prev_r_q,    prev_r_d;
  logic [WIDTH-1:0]       hold_l_q,    hold_l_d;
  logic [WIDTH-1:0]       hold_r_q,    hold_r_d;
  logic                   hold_full_q, hold_full_d;
  logic [7:0]             underrun_q,  underrun_d;
  logic                   run_q;

  logic                   fall;
  logic                   frame_load;
  logic                   xfer;
  logic [WIDTH-1:0]       load_l;
  logic [WIDTH-1:0]       load_r;
  logic [2*SLOT_BITS-1:0] frame_img;

  always_comb begin
    // run_q keeps ready low for the whole reset period and releases it one
    // cycle after reset drops.
    sample_ready = run_q & ~hold_full_q;
    xfer         = sample_valid & sample_ready;
    fall         = tick & sclk_q;
    frame_load   = fall & (bit_cnt_q == 6'd63);

    // An empty holding register at frame load replays the previous pair.
    load_l    = hold_full_q ? hold_l_q : prev_l_q;
    load_r    = hold_full_q ? hold_r_q : prev_r_q;
    frame_img = {place_slot(SLOT_BITS'(load_l), fmt_e'(fmt), WIDTH),
                 place_slot(SLOT_BITS'(load_r), fmt_e'(fmt), WIDTH)};

    sclk_d      = sclk_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    prev_l_d    = prev_l_q;
    prev_r_d    = prev_r_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;

    if (tick) begin
      sclk_d = ~sclk_q;
    end

    if (fall) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrclk_d   = bit_cnt_d[5];
      if (frame_load) begin
        // The whole frame image (format included) is latched here, so a
        // later fmt change only takes effect at the next load.
        sdata_d  = frame_img[2*SLOT_BITS-1];
        shift_d  = {frame_img[2*SLOT_BITS-2:0], 1'b0};
        prev_l_d = load_l;
        prev_r_d = load_r;
        if (hold_full_q) begin
          hold_full_d = 1'b0;
        end else if (underrun_q != 8'hFF) begin
          underrun_d = underrun_q + 8'd1;
        end
      end else begin
        sdata_d = shift_q[2*SLOT_BITS-1];
        shift_d = {shift_q[2*SLOT_BITS-2:0], 1'b0};
      end
    end

    // A transfer only happens with the holding register empty, so it can
    // never collide with the load that drains a full one.
    if (xfer) begin
      hold_l_d    = left ^ MSB_FLIP;
      hold_r_d    = right ^ MSB_FLIP;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      bit_cnt_q   <= 6'd63;
      shift_q     <= '0;
      prev_l_q    <= '0;
      prev_r_q    <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 8'd0;
      run_q       <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      prev_l_q    <= prev_l_d;
      prev_r_q    <= prev_r_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      run_q       <= 1'b1;
    end
  end

  assign sclk         = sclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun_cnt = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_audio_i2s_tx                                                 |
// | Purpose  : Self-checking bench for audio_i2s_tx. Three instances:          |
// |            0: W16 signed, 12.288 MHz / 48 kHz                              |
// |            1: W24 signed, 12.288 MHz / 48 kHz                              |
// |            2: W8 offset-binary, 12.288 MHz / 96 kHz (tick every clock)     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_audio_i2s_tx;

  localparam int FRAME_TIMEOUT = 1200;

  logic        clk;
  logic        rst;
  logic [1:0]  fmt;
  logic [2:0]  val_v;
  logic [2:0]  rdy_v;
  logic [2:0]  sclk_v;
  logic [2:0]  lr_v;
  logic [2:0]  sd_v;
  logic [7:0]  ur_a [3];
  logic [15:0] l16, r16;
  logic [23:0] l24, r24;
  logic [7:0]  l8, r8;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected frames pushed at stimulus time, captured frames
  // ({sdata bits, lrclk bits}, first wire bit in the MSB) pushed by the monitor.
  logic [63:0]  exp0 [$];
  logic [63:0]  exp1 [$];
  logic [63:0]  exp2 [$];
  logic [127:0] got0 [$];
  logic [127:0] got1 [$];
  logic [127:0] got2 [$];
  int           mon_cnt [3];

  audio_i2s_tx #(.CLK_RATE(12_288_000), .SAMPLE_RATE(48_000), .WIDTH(16), .SIGNED_IN(1)) u16 (
    .clk_sys(clk), .reset(rst), .fmt(fmt), .left(l16), .right(r16),
    .sample_valid(val_v[0]), .sample_ready(rdy_v[0]), .sclk(sclk_v[0]),
    .lrclk(lr_v[0]), .sdata(sd_v[0]), .underrun_cnt(ur_a[0]));

  audio_i2s_tx #(.CLK_RATE(12_288_000), .SAMPLE_RATE(48_000), .WIDTH(24), .SIGNED_IN(1)) u24 (
    .clk_sys(clk), .reset(rst), .fmt(fmt), .left(l24), .right(r24),
    .sample_valid(val_v[1]), .sample_ready(rdy_v[1]), .sclk(sclk_v[1]),
    .lrclk(lr_v[1]), .sdata(sd_v[1]), .underrun_cnt(ur_a[1]));

  audio_i2s_tx #(.CLK_RATE(12_288_000), .SAMPLE_RATE(96_000), .WIDTH(8), .SIGNED_IN(0)) u8 (
    .clk_sys(clk), .reset(rst), .fmt(fmt), .left(l8), .right(r8),
    .sample_valid(val_v[2]), .sample_ready(rdy_v[2]), .sclk(sclk_v[2]),
    .lrclk(lr_v[2]), .sdata(sd_v[2]), .underrun_cnt(ur_a[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: one wire bit per falling sclk; bit count restarts at reset so
  // the first falling edge after reset is position 0 of frame 0.
  initial begin
    logic [2:0]  sclk_prev;
    logic [63:0] acc_sd [3];
    logic [63:0] acc_lr [3];
    sclk_prev = '0;
    for (int k = 0; k < 3; k++) begin
      mon_cnt[k] = 0; acc_sd[k] = '0; acc_lr[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          mon_cnt[k]   = 0;
          sclk_prev[k] = 1'b0;
        end else begin
          if (sclk_prev[k] && !sclk_v[k]) begin
            acc_sd[k] = {acc_sd[k][62:0], sd_v[k]};
            acc_lr[k] = {acc_lr[k][62:0], lr_v[k]};
            mon_cnt[k]++;
            if (mon_cnt[k] == 64) begin
              case (k)
                0:       got0.push_back({acc_sd[k], acc_lr[k]});
                1:       got1.push_back({acc_sd[k], acc_lr[k]});
                default: got2.push_back({acc_sd[k], acc_lr[k]});
              endcase
              mon_cnt[k] = 0;
            end
          end
          sclk_prev[k] = sclk_v[k];
        end
      end
    end
  end

  // Reference frame: walk every slot position and decide which sample bit,
  // if any, belongs there.
  function automatic logic [63:0] model_frame(input int w, input logic [1:0] f,
                                              input logic [23:0] l, input logic [23:0] r,
                                              input bit uns);
    logic [63:0] fr;
    logic [23:0] s;
    int start;
    fr = '0;
    start = (f == 2'd1) ? 0 : (f == 2'd2) ? 32 - w : 1;
    for (int slot = 0; slot < 2; slot++) begin
      s = (slot == 0) ? l : r;
      if (uns) s[w-1] = ~s[w-1];
      for (int p = 0; p < 32; p++)
        if (p >= start && p < start + w)
          fr[63 - (slot*32 + p)] = s[w-1-(p-start)];
    end
    return fr;
  endfunction

  task automatic do_reset(input logic [1:0] f);
    @(posedge clk); #1;
    rst = 1'b1; fmt = f; val_v = '0;
    repeat (3) @(posedge clk);
    #1;
    got0.delete(); got1.delete(); got2.delete();
    exp0.delete(); exp1.delete(); exp2.delete();
    rst = 1'b0;
  endtask

  task automatic send(input int k, input logic [23:0] l, input logic [23:0] r);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    case (k)
      0:       begin l16 = l[15:0]; r16 = r[15:0]; end
      1:       begin l24 = l;       r24 = r;       end
      default: begin l8  = l[7:0];  r8  = r[7:0];  end
    endcase
    val_v[k] = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (rdy_v[k]) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    val_v[k] = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_handshake dut%0d: sample_ready never seen, required 1", k);
    end
  endtask

  task automatic get_frame(input int k, output logic [127:0] f, output bit ok);
    ok = 1'b0;
    f  = '0;
    for (int i = 0; i < FRAME_TIMEOUT && !ok; i++) begin
      case (k)
        0:       if (got0.size() > 0) begin f = got0.pop_front(); ok = 1'b1; end
        1:       if (got1.size() > 0) begin f = got1.pop_front(); ok = 1'b1; end
        default: if (got2.size() > 0) begin f = got2.pop_front(); ok = 1'b1; end
      endcase
      if (!ok) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; val_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (rdy_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b required 0", k, rdy_v[k]); end
      n_checks++; if (sclk_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_sclk dut%0d: got %b required 0", k, sclk_v[k]); end
      n_checks++; if (lr_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_lrclk dut%0d: got %b required 0", k, lr_v[k]); end
      n_checks++; if (sd_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_sdata dut%0d: got %b required 0", k, sd_v[k]); end
      n_checks++; if (ur_a[k] !== 8'd0) begin n_fail++; $display("FAIL reset_underrun dut%0d: got %0d required 0", k, ur_a[k]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rdy_v !== 3'b111) begin n_fail++; $display("FAIL reset_release_ready: got %b required 111", rdy_v); end
  endtask

  task automatic test_clock_rates();
    int r1, r2, q1, q2;
    logic ps, pl;
    r1 = -1; r2 = -1; q1 = -1; q2 = -1;
    do_reset(2'd0);
    ps = 1'b0; pl = 1'b0;
    for (int c = 0; c < 1200 && q2 < 0; c++) begin
      @(negedge clk);
      if (!ps && sclk_v[0]) begin
        if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
      end
      if (!pl && lr_v[0]) begin
        if (q1 < 0) q1 = c; else if (q2 < 0) q2 = c;
      end
      ps = sclk_v[0];
      pl = lr_v[0];
    end
    n_checks++;
    if (r1 < 0 || r2 < 0 || r2 - r1 != 4) begin n_fail++; $display("FAIL sclk_period: got %0d clocks required 4", r2 - r1); end
    n_checks++;
    if (q1 < 0 || q2 < 0 || q2 - q1 != 256) begin n_fail++; $display("FAIL lrclk_period: got %0d clocks required 256", q2 - q1); end
  endtask

  task automatic test_i2s_basic();
    logic [127:0] f;
    bit ok;
    logic [63:0] e;
    do_reset(2'd0);
    exp0.push_back(64'h52AD0000_00008000);
    exp0.push_back(64'h52AD0000_00008000);
    send(0, 24'h00A55A, 24'h000001);
    for (int n = 0; n < 2; n++) begin
      get_frame(0, f, ok);
      e = exp0.pop_front();
      n_checks++;
      if (!ok || f[127:64] !== e) begin n_fail++; $display("FAIL i2s16_frame%0d: got %h required %h (arrived=%0d)", n, f[127:64], e, ok); end
      n_checks++;
      if (!ok || f[63:0] !== 64'h00000000_FFFFFFFF) begin n_fail++; $display("FAIL i2s16_lrclk%0d: got %h required 00000000ffffffff", n, f[63:0]); end
    end
  endtask

  task automatic test_rj_lj_24();
    logic [127:0] f;
    bit ok;
    logic [63:0] e;
    do_reset(2'd2);
    exp1.push_back(64'h00800001_00000000);
    send(1, 24'h800001, 24'h000000);
    get_frame(1, f, ok);
    e = exp1.pop_front();
    n_checks++;
    if (!ok || f[127:64] !== e) begin n_fail++; $display("FAIL rj24_frame: got %h required %h", f[127:64], e); end
    do_reset(2'd1);
    exp1.push_back(64'h80000100_00000000);
    send(1, 24'h800001, 24'h000000);
    get_frame(1, f, ok);
    e = exp1.pop_front();
    n_checks++;
    if (!ok || f[127:64] !== e) begin n_fail++; $display("FAIL lj24_frame: got %h required %h", f[127:64], e); end
  endtask

  task automatic test_unsigned_8();
    logic [127:0] f;
    bit ok;
    logic [63:0] e;
    do_reset(2'd0);
    // Instance 2 ticks every clock, so its first load lands on the transfer
    // cycle: frame 0 is an underrun replay of the reset pair.
    exp2.push_back(64'h0);
    exp2.push_back(64'h00000000_7F800000);
    send(2, 24'h000080, 24'h00007F);
    for (int n = 0; n < 2; n++) begin
      get_frame(2, f, ok);
      e = exp2.pop_front();
      n_checks++;
      if (!ok || f[127:64] !== e) begin n_fail++; $display("FAIL uns8_frame%0d: got %h required %h", n, f[127:64], e); end
    end
    n_checks++;
    if (ur_a[2] !== 8'd1) begin n_fail++; $display("FAIL uns8_underrun: got %0d required 1", ur_a[2]); end
  endtask

  task automatic test_fmt_midframe();
    logic [127:0] f;
    bit ok;
    logic [63:0] e;
    logic [23:0] l, r;
    bit seen;
    l = 24'($urandom_range(0, 65535));
    r = 24'($urandom_range(0, 65535));
    do_reset(2'd0);
    exp0.push_back(model_frame(16, 2'd0, l, r, 1'b0));
    exp0.push_back(model_frame(16, 2'd1, l, r, 1'b0));
    send(0, l, r);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (mon_cnt[0] >= 5) seen = 1'b1;
    end
    fmt = 2'd1;
    for (int n = 0; n < 2; n++) begin
      get_frame(0, f, ok);
      e = exp0.pop_front();
      n_checks++;
      if (!seen || !ok || f[127:64] !== e) begin n_fail++; $display("FAIL fmt_switch_frame%0d: got %h required %h", n, f[127:64], e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] f;
    bit ok;
    logic [63:0] e;
    logic [23:0] pl [3];
    logic [23:0] pr [3];
    do_reset(2'd3);
    for (int i = 0; i < 3; i++) begin
      pl[i] = 24'($urandom_range(0, 65535));
      pr[i] = 24'($urandom_range(0, 65535));
      exp0.push_back(model_frame(16, 2'd3, pl[i], pr[i], 1'b0));
    end
    exp0.push_back(model_frame(16, 2'd3, pl[2], pr[2], 1'b0));
    for (int i = 0; i < 3; i++) send(0, pl[i], pr[i]);
    for (int n = 0; n < 4; n++) begin
      get_frame(0, f, ok);
      e = exp0.pop_front();
      n_checks++;
      if (!ok || f[127:64] !== e) begin n_fail++; $display("FAIL b2b_frame%0d: got %h required %h", n, f[127:64], e); end
    end
    n_checks++;
    if (ur_a[0] !== 8'd1) begin n_fail++; $display("FAIL b2b_underrun: got %0d required 1", ur_a[0]); end
  endtask

  task automatic test_underrun();
    logic [127:0] f;
    bit ok, alive;
    int bad;
    logic [23:0] l, r;
    logic [63:0] e;
    l = 24'($urandom_range(0, 255));
    r = 24'($urandom_range(0, 255));
    do_reset(2'd2);
    e = model_frame(8, 2'd2, l, r, 1'b1);
    exp2.push_back(64'h0);
    send(2, l, r);
    bad = 0;
    alive = 1'b1;
    for (int n = 0; n < 262 && alive; n++) begin
      get_frame(2, f, ok);
      if (!ok) begin
        alive = 1'b0;
        n_checks++; n_fail++;
        $display("FAIL underrun_frame_timeout: frame %0d not produced, required within %0d cycles", n, FRAME_TIMEOUT);
      end else if (n == 0) begin
        n_checks++;
        if (f[127:64] !== exp2.pop_front()) begin n_fail++; $display("FAIL underrun_first_frame: got %h required 0", f[127:64]); end
      end else begin
        if (f[127:64] !== e) bad++;
        if (n == 4) begin
          n_checks++;
          if (ur_a[2] !== 8'd4) begin n_fail++; $display("FAIL underrun_count5: got %0d required 4", ur_a[2]); end
        end
      end
    end
    n_checks++;
    if (!alive || bad != 0) begin n_fail++; $display("FAIL underrun_repeat: %0d frames differ from %h, required 0", bad, e); end
    n_checks++;
    if (ur_a[2] !== 8'd255) begin n_fail++; $display("FAIL underrun_saturate: got %0d required 255", ur_a[2]); end
  endtask

  task automatic test_reset_midframe();
    bit seen;
    do_reset(2'd2);
    send(0, 24'h00FFFF, 24'h00FFFF);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (mon_cnt[0] == 21) seen = 1'b1;
    end
    // Position 20 of an RJ 16-bit slot carries a sample bit, here a 1.
    n_checks++;
    if (!seen || sd_v[0] !== 1'b1) begin n_fail++; $display("FAIL midframe_pre_sdata: got %b required 1 (reached=%0d)", sd_v[0], seen); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (sclk_v[0] !== 1'b0) begin n_fail++; $display("FAIL midframe_sclk: got %b required 0", sclk_v[0]); end
    n_checks++; if (lr_v[0] !== 1'b0) begin n_fail++; $display("FAIL midframe_lrclk: got %b required 0", lr_v[0]); end
    n_checks++; if (sd_v[0] !== 1'b0) begin n_fail++; $display("FAIL midframe_sdata: got %b required 0", sd_v[0]); end
    n_checks++; if (rdy_v[0] !== 1'b0) begin n_fail++; $display("FAIL midframe_ready: got %b required 0", rdy_v[0]); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rdy_v[0] !== 1'b1) begin n_fail++; $display("FAIL midframe_release_ready: got %b required 1", rdy_v[0]); end
  endtask

  initial begin
    rst = 1'b1; fmt = 2'd0; val_v = '0;
    l16 = '0; r16 = '0; l24 = '0; r24 = '0; l8 = '0; r8 = '0;
    test_reset();
    test_clock_rates();
    test_i2s_basic();
    test_rj_lj_24();
    test_unsigned_8();
    test_fmt_midframe();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
